// File: rtl/dual_cam_fb_pkg.sv
// Shared constants, entry/channel types and pixel helpers for the dual-camera
// frame-buffer writer.
package dual_cam_fb_pkg;

  localparam int unsigned FB_WIDTH   = 320;
  localparam int unsigned FB_HEIGHT  = 240;
  localparam int unsigned HALF_WIDTH = 160;
  localparam int unsigned CAM_W      = 640;
  localparam int unsigned CAM_H      = 480;

  localparam int unsigned FB_ADDR_W  = 17;
  localparam int unsigned FB_DATA_W  = 12;

  typedef enum logic {
    CAM1 = 1'b0,
    CAM2 = 1'b1
  } cam_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_entry_t;

  // g = (R + 2G + B) >> 2 on a 6-bit sum, replicated into all three channels.
  function automatic logic [FB_DATA_W-1:0] rgb444_to_gray(input logic [FB_DATA_W-1:0] rgb);
    logic [5:0] sum;
    sum = {2'b00, rgb[11:8]} + {1'b0, rgb[7:4], 1'b0} + {2'b00, rgb[3:0]};
    return {sum[5:2], sum[5:2], sum[5:2]};
  endfunction

endpackage

// File: rtl/dual_cam_fb_fifo.sv
// Single-clock FIFO of DEPTH entries (power of two, >= 2).
// Ports: clk, reset_n (sync, active-low), push/push_data, pop/pop_data,
// full, empty. A push while full is taken only if a pop happens in the same cycle.
module dual_cam_fb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 29
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop   = reset_n && pop && !empty;
  assign do_push  = reset_n && push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dual_cam_fb_writer.sv
// Merges two camera pixel streams into one 320x240 RGB444 frame-buffer write
// port. Each 640x480 stream is decimated to 160x240; cam1 fills columns
// 0..159, cam2 columns 160..319. One FIFO per channel, round-robin arbiter,
// registered write port.
// Ports: clk, i_reset_n (sync, active-low); per camera i_we/i_data/i_line/
// i_pixel; i_clear clears o_overflow; o_we/o_addr/o_data write port;
// o_overflow[0]=cam1, [1]=cam2 sticky drop flags.
// Option: define DUAL_CAM_FB_GRAY_EN to write grayscale {g,g,g} instead of RGB.
module dual_cam_fb_writer
  import dual_cam_fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned CAM_LINE   = 9,
  parameter int unsigned CAM_PIXEL  = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_we_cam1,
  input  logic [DATA_WIDTH-1:0] i_data_cam1,
  input  logic [CAM_LINE-1:0]   i_line_cam1,
  input  logic [CAM_PIXEL-1:0]  i_pixel_cam1,
  input  logic                  i_we_cam2,
  input  logic [DATA_WIDTH-1:0] i_data_cam2,
  input  logic [CAM_LINE-1:0]   i_line_cam2,
  input  logic [CAM_PIXEL-1:0]  i_pixel_cam2,
  input  logic                  i_clear,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_overflow
);

  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

  logic                  qual1, qual2;
  logic [EW-1:0]         wr1, wr2;
  logic [EW-1:0]         rd1, rd2;
  logic                  full1, full2;
  logic                  empty1, empty2;
  logic                  grant1, grant2;
  logic                  drop1, drop2;
  cam_t                  last;
  logic [EW-1:0]         sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic qualify(input logic                 we,
                                   input logic [CAM_LINE-1:0]  line,
                                   input logic [CAM_PIXEL-1:0] pixel);
    return we && (pixel[1:0] == 2'b00) && !line[0]
           && (pixel < CAM_PIXEL'(CAM_W)) && (line < CAM_LINE'(CAM_H));
  endfunction

  // y*320 as (y<<8)+(y<<6); cam2 lands in the right half.
  function automatic logic [ADDR_WIDTH-1:0] fb_addr(input logic [CAM_LINE-1:0]  line,
                                                    input logic [CAM_PIXEL-1:0] pixel,
                                                    input cam_t                 ch);
    logic [ADDR_WIDTH-1:0] y, x, off;
    y   = ADDR_WIDTH'(line[CAM_LINE-1:1]);
    x   = ADDR_WIDTH'(pixel[CAM_PIXEL-1:2]);
    off = (ch == CAM2) ? ADDR_WIDTH'(HALF_WIDTH) : '0;
    return (y << 8) + (y << 6) + x + off;
  endfunction

  assign qual1 = qualify(i_we_cam1, i_line_cam1, i_pixel_cam1);
  assign qual2 = qualify(i_we_cam2, i_line_cam2, i_pixel_cam2);
  assign wr1   = {fb_addr(i_line_cam1, i_pixel_cam1, CAM1), i_data_cam1};
  assign wr2   = {fb_addr(i_line_cam2, i_pixel_cam2, CAM2), i_data_cam2};

  dual_cam_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo_cam1 (
    .clk       (clk),
    .reset_n   (i_reset_n),
    .push      (qual1),
    .push_data (wr1),
    .pop       (grant1),
    .pop_data  (rd1),
    .full      (full1),
    .empty     (empty1)
  );

  dual_cam_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo_cam2 (
    .clk       (clk),
    .reset_n   (i_reset_n),
    .push      (qual2),
    .push_data (wr2),
    .pop       (grant2),
    .pop_data  (rd2),
    .full      (full2),
    .empty     (empty2)
  );

  // Round robin: on contention the channel not granted last wins.
  assign grant1 = !empty1 && (empty2 || (last == CAM2));
  assign grant2 = !empty2 && (empty1 || (last == CAM1));

  assign drop1 = qual1 && full1 && !grant1;
  assign drop2 = qual2 && full2 && !grant2;

  always_comb begin
    sel      = grant2 ? rd2 : rd1;
    sel_addr = sel[EW-1:DATA_WIDTH];
`ifdef DUAL_CAM_FB_GRAY_EN
    sel_data = DATA_WIDTH'(rgb444_to_gray(FB_DATA_W'(sel[DATA_WIDTH-1:0])));
`else
    sel_data = sel[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      o_we       <= 1'b0;
      o_addr     <= '0;
      o_data     <= '0;
      o_overflow <= '0;
      last       <= CAM2;
    end else begin
      o_we <= grant1 || grant2;
      if (grant1 || grant2) begin
        o_addr <= sel_addr;
        o_data <= sel_data;
        last   <= grant2 ? CAM2 : CAM1;
      end
      // A drop in the same cycle as i_clear leaves the bit set.
      o_overflow[0] <= drop1 ? 1'b1 : (i_clear ? 1'b0 : o_overflow[0]);
      o_overflow[1] <= drop2 ? 1'b1 : (i_clear ? 1'b0 : o_overflow[1]);
    end
  end

endmodule

// File: tb/tb_dual_cam_fb_writer.sv
// Scoreboard bench for dual_cam_fb_writer: a queue-based reference model
// predicts every frame-buffer write and the overflow flags edge by edge.
module tb_dual_cam_fb_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NCYC  = 8192;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_we_cam1 = 1'b0, i_we_cam2 = 1'b0;
  logic [11:0] i_data_cam1 = '0, i_data_cam2 = '0;
  logic [8:0]  i_line_cam1 = '0, i_line_cam2 = '0;
  logic [9:0]  i_pixel_cam1 = '0, i_pixel_cam2 = '0;
  logic        i_clear = 1'b0;
  logic        o_we;
  logic [16:0] o_addr;
  logic [11:0] o_data;
  logic [1:0]  o_overflow;

  always #5 clk = ~clk;

  dual_cam_fb_writer #(
    .ADDR_WIDTH (17),
    .DATA_WIDTH (12),
    .CAM_LINE   (9),
    .CAM_PIXEL  (10),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .i_reset_n    (i_reset_n),
    .i_we_cam1    (i_we_cam1),
    .i_data_cam1  (i_data_cam1),
    .i_line_cam1  (i_line_cam1),
    .i_pixel_cam1 (i_pixel_cam1),
    .i_we_cam2    (i_we_cam2),
    .i_data_cam2  (i_data_cam2),
    .i_line_cam2  (i_line_cam2),
    .i_pixel_cam2 (i_pixel_cam2),
    .i_clear      (i_clear),
    .o_we         (o_we),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .o_overflow   (o_overflow)
  );

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned edge_n;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned mq1[$];
  int unsigned mq2[$];
  int unsigned m_last = 1;
  bit [1:0]    m_ovf  = 2'b00;
  bit [1:0]    ovf_exp [NCYC];
  bit          rst_at  [NCYC];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit m_qual(bit we, int unsigned p, int unsigned l);
    return we && (p % 4 == 0) && (l % 2 == 0) && (p < 640) && (l < 480);
  endfunction

  function automatic int unsigned m_addr(int unsigned p, int unsigned l, int unsigned ch);
    return (l / 2) * 320 + p / 4 + ((ch == 2) ? 160 : 0);
  endfunction

  function automatic int unsigned m_data(int unsigned d);
`ifdef DUAL_CAM_FB_GRAY_EN
    int unsigned gy;
    gy = (((d >> 8) & 15) + 2 * ((d >> 4) & 15) + (d & 15)) / 4;
    return gy * 'h111;
`else
    return d;
`endif
  endfunction

  // Drives one cycle of inputs and advances the model to the following edge.
  task automatic step(input bit rst_n,
                      input bit we1, input int unsigned p1, input int unsigned l1, input int unsigned d1,
                      input bit we2, input int unsigned p2, input int unsigned l2, input int unsigned d2,
                      input bit clr);
    int unsigned e, v;
    bit g1, g2;
    @(negedge clk);
    i_reset_n    = rst_n;
    i_we_cam1    = we1;  i_pixel_cam1 = 10'(p1); i_line_cam1 = 9'(l1); i_data_cam1 = 12'(d1);
    i_we_cam2    = we2;  i_pixel_cam2 = 10'(p2); i_line_cam2 = 9'(l2); i_data_cam2 = 12'(d2);
    i_clear      = clr;
    e = cyc + 1;
    if (!rst_n) begin
      mq1.delete();
      mq2.delete();
      m_last = 2;
      m_ovf  = 2'b00;
      if (e < NCYC) rst_at[e] = 1'b1;
    end else begin
      g1 = (mq1.size() > 0) && (mq2.size() == 0 || m_last == 2);
      g2 = !g1 && (mq2.size() > 0);
      if (g1) begin
        v = mq1.pop_front();
        exp_q.push_back('{v / 4096, m_data(v % 4096), e});
        m_last = 1;
      end else if (g2) begin
        v = mq2.pop_front();
        exp_q.push_back('{v / 4096, m_data(v % 4096), e});
        m_last = 2;
      end
      if (clr) m_ovf = 2'b00;
      if (m_qual(we1, p1, l1)) begin
        if (mq1.size() < DEPTH) mq1.push_back(m_addr(p1, l1, 1) * 4096 + d1);
        else m_ovf[0] = 1'b1;
      end
      if (m_qual(we2, p2, l2)) begin
        if (mq2.size() < DEPTH) mq2.push_back(m_addr(p2, l2, 2) * 4096 + d2);
        else m_ovf[1] = 1'b1;
      end
    end
    if (e < NCYC) ovf_exp[e] = m_ovf;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic rnd_sample(output int unsigned p, output int unsigned l, output int unsigned d);
    p = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 159) * 4 : $urandom_range(0, 1023);
    l = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 239) * 2 : $urandom_range(0, 511);
    d = $urandom_range(0, 4095);
  endtask

  // Monitor: compares every edge against the model's prediction.
  always @(negedge clk) begin
    if (!done && cyc > 0 && cyc < NCYC) begin
      n_chk++;
      if (o_overflow !== ovf_exp[cyc]) begin
        n_fail++;
        $display("FAIL overflow @edge %0d: got %b expected %b", cyc, o_overflow, ovf_exp[cyc]);
      end
      if (rst_at[cyc]) begin
        n_chk++;
        if (o_we !== 1'b0 || o_addr !== '0 || o_data !== '0) begin
          n_fail++;
          $display("FAIL reset_values @edge %0d: got we=%b addr=%0d data=%h expected 0/0/0",
                   cyc, o_we, o_addr, o_data);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
        n_chk++;
        if (o_we !== 1'b1) begin
          n_fail++;
          $display("FAIL missing_write @edge %0d: got we=%b expected we=1 addr=%0d data=%h",
                   cyc, o_we, exp_q[0].addr, exp_q[0].data);
        end else if (32'(o_addr) != exp_q[0].addr || 32'(o_data) != exp_q[0].data) begin
          n_fail++;
          $display("FAIL write_content @edge %0d: got addr=%0d data=%h expected addr=%0d data=%h",
                   cyc, o_addr, o_data, exp_q[0].addr, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end else begin
        n_chk++;
        if (o_we !== 1'b0) begin
          n_fail++;
          $display("FAIL unexpected_write @edge %0d: got we=%b addr=%0d data=%h expected we=0",
                   cyc, o_we, o_addr, o_data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p1, l1, d1, p2, l2, d2, rate;
    bit w1, w2;
    rst_at[1] = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

    // Single cam1 sample -> addr 962 two cycles later.
    step(1'b1, 1, 8, 6, 'hABC, 0, 0, 0, 0, 1'b0);
    idle(4);
    // Bottom-right corner for cam2, then unqualified samples.
    step(1'b1, 0, 0, 0, 0, 1, 636, 478, 'h123, 1'b0);
    step(1'b1, 1, 641, 0, 'h111, 1, 5, 2, 'h222, 1'b0);
    step(1'b1, 1, 4, 7, 'h333, 1, 8, 480, 'h444, 1'b0);
    step(1'b1, 0, 0, 0, 0, 1, 1020, 2, 'h555, 1'b0);
    idle(4);
    step(1'b1, 1, 0, 0, 'hF80, 0, 0, 0, 0, 1'b0);
    idle(3);

    // Both busy, every 4th input qualified: alternating writes, no overflow.
    for (int i = 0; i < 20; i++)
      step(1'b1, 1, (i % 4 == 0) ? 4 * i : 4 * i + 1, 2 * i, 'h100 + i,
                 1, (i % 4 == 0) ? 4 * i : 4 * i + 2, 2 * i, 'h200 + i, 1'b0);
    idle(6);

    // Both qualified every cycle: overflow, clear alone, clear coincident with drops.
    for (int i = 0; i < 14; i++)
      step(1'b1, 1, 4 * i, 10, 'h300 + i, 1, 4 * i, 12, 'h400 + i, 1'b0);
    idle(8);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle(2);
    for (int i = 0; i < 12; i++)
      step(1'b1, 1, 4 * i, 20, 'h500 + i, 1, 4 * i, 22, 'h600 + i, (i >= 9));
    idle(8);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);

    // Fill both FIFOs, then reset mid-stream.
    for (int i = 0; i < 10; i++)
      step(1'b1, 1, 4 * i, 30, 'h700 + i, 1, 4 * i, 32, 'h800 + i, 1'b0);
    step(1'b0, 1, 40, 30, 'h7AA, 1, 40, 32, 'h8AA, 1'b0);
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    idle(6);

    // Randomized traffic with varying load, clears and rare resets.
    for (int seg = 0; seg < 15; seg++) begin
      case (seg % 3)
        0:       rate = 25;
        1:       rate = 55;
        default: rate = 95;
      endcase
      for (int i = 0; i < 200; i++) begin
        w1 = ($urandom_range(0, 99) < rate);
        w2 = ($urandom_range(0, 99) < rate);
        rnd_sample(p1, l1, d1);
        rnd_sample(p2, l2, d2);
        step(($urandom_range(0, 299) != 0), w1, p1, l1, d1, w2, p2, l2, d2,
             ($urandom_range(0, 19) == 0));
      end
    end

    idle(14);
    @(negedge clk);
    #1;
    done = 1'b1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding writes expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
